// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Q-format multiplier: one shift-add step per multiplier magnitude bit,
// then truncate to Q fractional bits with magnitude saturation on overflow.
module qmult_seq #(
   parameter int unsigned Q = 15,
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         busy,
   output logic         done,
   output logic         overflow
);

   localparam int unsigned AccW = 2 * N - 2;
   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [AccW-1:0]   a_sh_q, a_sh_d;
   logic [N-2:0]      b_sh_q, b_sh_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic [N-1:0]      c_q, c_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [AccW-1:0]   prod_hi;
   logic [AccW-1:0]   prod_scaled;
   logic              res_ovf;
   logic [N-2:0]      res_mag;
   logic [N-1:0]      res_c;

   // Result formation from the finished accumulator; bits above Q+N-2 mean saturation.
   always_comb begin
      prod_hi     = acc_q >> (Q + N - 1);
      prod_scaled = acc_q >> Q;
      res_ovf     = |prod_hi;
      res_mag     = res_ovf ? {(N-1){1'b1}} : prod_scaled[N-2:0];
      res_c       = {sign_q & (|res_mag), res_mag};
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      c_d     = c_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_sh_d  = {{(N-1){1'b0}}, a[N-2:0]};
               b_sh_d  = b[N-2:0];
               sign_d  = a[N-1] ^ b[N-1];
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cnt_q == LastCnt) begin
               c_d     = res_c;
               ovf_d   = res_ovf;
               state_d = StDone;
            end else begin
               if (b_sh_q[0]) begin
                  acc_d = acc_q + a_sh_q;
               end
               a_sh_d = a_sh_q << 1;
               b_sh_d = b_sh_q >> 1;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         c_q     <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign c        = c_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: doc/qmult_seq.md
# qmult_seq

Sequential sign-magnitude fixed-point multiplier that produces one product per multi-cycle operation. It uses the same Q/N sign-magnitude format as the adder stage it feeds, and sits directly upstream of that adder in the multiply-accumulate datapath. Together the two blocks form a MAC. It trades latency for area with one shift-add step per magnitude bit, and its start/busy/done handshake lets a controller sequence operands into it.

## Interface
- Q, 15, number of fractional bits
- N, 32, total word width (bit N-1 = sign, bits N-2:0 = magnitude)
- clk  in  1  rising-edge clock; only clock in the block
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled on a rising edge only when busy=0
- a  in  N  multiplicand, sign-magnitude Q format; sampled with accepted start
- b  in  N  multiplier, sign-magnitude Q format; sampled with accepted start
- c  out  N  product, sign-magnitude Q format; registered
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: c and overflow updated this cycle
- overflow  out  1  product magnitude saturated; valid with done, held until next done

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset (rst=1 at an edge) forces: state=IDLE, c=0, busy=0, done=0, overflow=0, internal accumulator and counter cleared.
- Reset mid-operation aborts the operation. No done is produced for it.
- IDLE, start=1: latch |a|, |b|, and sign a[N-1]^b[N-1]; clear the 2N-2-bit accumulator and the bit counter; go to RUN.
- RUN: one step per cycle, processing multiplier magnitude bits LSB first, N-1 steps total.
  - Each step: if the current bit of |b| is set, add |a|, shifted by the bit index, into the accumulator.
  - Equivalent shift-right-accumulator implementations are allowed if bit-exact.
- After N-1 steps, form the result and go to DONE.
  - Full product P = |a|·|b| (2N-2 bits). Scaled magnitude M = P >> Q; truncate, no rounding.
  - If any bit of P above position Q+N-2 is set: overflow=1 and magnitude=all ones (2^(N-1)-1).
  - Otherwise: overflow=0 and magnitude = P[Q+N-2:Q].
  - c[N-2:0] = magnitude. c[N-1] = latched sign, except a zero magnitude forces sign 0 (never emit negative zero).
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- start while busy=1 is ignored, not queued. a and b may change freely while busy.
- c and overflow hold their last values until the next DONE or reset.

## Timing
- Edge E0 accepts start: busy=1 from just after E0 until just after E_N, i.e. N cycles.
- At E_N: c and overflow registered, done=1, busy=0 for one cycle.
- Result latency: N cycles from the accepting edge to c valid.
- Maximum throughput: one product per N+1 cycles (start held high continuously).
- busy and done are never both 1.
- Outputs come directly from registers, with no combinational path from inputs.
- The adder downstream may consume c combinationally during the done cycle or any later cycle.

## Test plan
Defaults N=32, Q=15 (1.0 = 0x00008000).
- Reset, then a=0x0000C000 (1.5), b=0x00010000 (2.0), start pulse -> busy high 32 cycles, then done pulse with c=0x00018000, overflow=0. All outputs read 0 before the first start.
- Sign and zero handling:
  - a=0x8000C000, b=0x00010000 -> c=0x80018000.
  - a=0x80000000 (negative zero), b=0x00028000 -> c=0x00000000 (sign 0).
  - a=0x00000001, b=0x80000001 -> c=0x00000000 (truncation, no negative zero).
- Overflow: a=0x40000000, b=0x00010000 -> c=0x7FFFFFFF, overflow=1. Same with b=0x80010000 -> c=0xFFFFFFFF, overflow=1. A following in-range operation clears overflow.
- Handshake:
  - Start pulses during busy with different operands are ignored; the result matches the first operands.
  - Start held high -> results complete every 33 cycles, each done exactly one cycle wide.
- Reset at cycle 10 of a run -> next edge: busy=0, done=0, c=0. No done follows. A new start afterwards yields a correct product.
- Random regression of 10k operand pairs against a reference model (truncate, saturate, no negative zero) -> bit-exact c and overflow.
